// File: rtl/multi_chan_sync.sv
// N-channel input synchronizer bank with rise/fall pulses and sticky event flags.
// Optional glitch filter after the chain is enabled by defining MULTI_SYNC_FILTER_EN.
module multi_chan_sync #(
    parameter int CHANNELS    = 8,
    parameter int STAGES      = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [CHANNELS-1:0] async_in,
    input  logic [CHANNELS-1:0] flag_clr,
    output logic [CHANNELS-1:0] sync_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] event_flags,
    output logic                event_any
);

    localparam int SD = (STAGES < 2) ? 2 : STAGES;

    logic [CHANNELS-1:0] r_chain [SD];
    logic [CHANNELS-1:0] r_prev;
    logic [CHANNELS-1:0] r_flags;
    logic [CHANNELS-1:0] w_level;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;

    // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SD; i++) begin
                r_chain[i] <= '0;
            end
        end else if (ena) begin
            r_chain[0] <= async_in;
            for (int i = 1; i < SD; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

`ifdef MULTI_SYNC_FILTER_EN
    localparam int FL = (FILT_CYCLES < 1) ? 1 : ((FILT_CYCLES > 255) ? 255 : FILT_CYCLES);
    localparam logic [7:0] FL_LAST = 8'(FL - 1);

    logic [7:0]          r_cnt [CHANNELS];
    logic [CHANNELS-1:0] r_filt;

    // Filtered level only follows the chain once it has disagreed for FL consecutive enabled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_cnt[c] <= 8'd0;
            end
        end else if (ena) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (r_chain[SD-1][c] != r_filt[c]) begin
                    if (r_cnt[c] >= FL_LAST) begin
                        r_filt[c] <= r_chain[SD-1][c];
                        r_cnt[c]  <= 8'd0;
                    end else if (r_cnt[c] != 8'hFF) begin
                        r_cnt[c] <= r_cnt[c] + 8'd1;
                    end
                end else begin
                    r_cnt[c] <= 8'd0;
                end
            end
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_chain[SD-1];
`endif

    // Pulses are gated by ena; r_prev only advances when enabled, so a held edge is reported later.
    assign w_rise = {CHANNELS{ena}} &  w_level & ~r_prev;
    assign w_fall = {CHANNELS{ena}} & ~w_level &  r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= '0;
            r_flags <= '0;
        end else if (ena) begin
            r_prev  <= w_level;
            r_flags <= (r_flags & ~flag_clr) | w_rise | w_fall;
        end
    end

    assign sync_out    = w_level;
    assign rise_pulse  = w_rise;
    assign fall_pulse  = w_fall;
    assign event_flags = r_flags;
    assign event_any   = |r_flags;

endmodule
